// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and BCD digit widths for the round timer
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int MIN_W  = 4;
    localparam int TENS_W = 3;
    localparam int ONES_W = 4;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - slow-clock synchronizer with rising-edge and any-edge strobes
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic any_edge
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] fill_q;
    logic              synced;
    logic              synced_d;
    logic              armed;

    assign synced = sync_q[STAGES-1];

    // Strobes stay off until the chain holds real input and has seen it low,
    // so an input already high at reset release is not taken as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            fill_q   <= '0;
            synced_d <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[STAGES-2:0], din};
            fill_q   <= {fill_q[STAGES-2:0], 1'b1};
            synced_d <= synced;
            armed    <= armed | (fill_q[STAGES-1] & ~synced);
        end
    end

    assign rise     = armed & synced & ~synced_d;
    assign any_edge = armed & (synced ^ synced_d);

endmodule

// File: rtl/round_timer.sv
// rtl/round_timer.sv - BCD M:SS round countdown with warn/blink and expiry strobe
module round_timer
    import timer_pkg::*;
#(
    parameter int ROUND_SECS  = 180,
    parameter int WARN_SECS   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              clk_500ms,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    output logic [MIN_W-1:0]  time_min,
    output logic [TENS_W-1:0] time_sec_tens,
    output logic [ONES_W-1:0] time_sec_ones,
    output logic              running,
    output logic              warn,
    output logic              blink,
    output logic              expired,
    output logic              expire_pulse
);

    localparam logic [MIN_W-1:0]  LD_MIN  = MIN_W'(ROUND_SECS / 60);
    localparam logic [TENS_W-1:0] LD_TENS = TENS_W'((ROUND_SECS % 60) / 10);
    localparam logic [ONES_W-1:0] LD_ONES = ONES_W'(ROUND_SECS % 10);
    localparam logic [MIN_W-1:0]  W_MIN   = MIN_W'(WARN_SECS / 60);
    localparam logic [TENS_W-1:0] W_TENS  = TENS_W'((WARN_SECS % 60) / 10);
    localparam logic [ONES_W-1:0] W_ONES  = ONES_W'(WARN_SECS % 10);

    state_t            state, state_nxt;
    logic [MIN_W-1:0]  min_nxt;
    logic [TENS_W-1:0] tens_nxt;
    logic [ONES_W-1:0] ones_nxt;
    logic              sec_tick, half_tick;
    logic              at_one, nxt_zero, nxt_above_warn;
    logic              warn_nxt, blink_nxt, blink_adv;

    edge_sync #(.STAGES(SYNC_STAGES)) u_edge_sync (
        .clk      (clk_100mhz),
        .rst_n    (rst_n),
        .din      (clk_500ms),
        .rise     (sec_tick),
        .any_edge (half_tick)
    );

    assign at_one = (time_min == '0) && (time_sec_tens == '0) && (time_sec_ones == ONES_W'(1));

    always_comb begin
        state_nxt = state;
        min_nxt   = time_min;
        tens_nxt  = time_sec_tens;
        ones_nxt  = time_sec_ones;
        blink_adv = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            min_nxt   = LD_MIN;
            tens_nxt  = LD_TENS;
            ones_nxt  = LD_ONES;
        end else if (start) begin
            state_nxt = RUN;
            min_nxt   = LD_MIN;
            tens_nxt  = LD_TENS;
            ones_nxt  = LD_ONES;
        end else if (pause) begin
            if (state == RUN)
                state_nxt = PAUSE;
            else if (state == PAUSE)
                state_nxt = RUN;
        end else if (state == RUN) begin
            blink_adv = half_tick;
            if (sec_tick) begin
                // Digit-wise borrow chain: ones 0->9, tens 0->5, then minutes.
                if (time_sec_ones != '0) begin
                    ones_nxt = time_sec_ones - ONES_W'(1);
                end else begin
                    ones_nxt = ONES_W'(9);
                    if (time_sec_tens != '0) begin
                        tens_nxt = time_sec_tens - TENS_W'(1);
                    end else begin
                        tens_nxt = TENS_W'(5);
                        min_nxt  = time_min - MIN_W'(1);
                    end
                end
                if (at_one)
                    state_nxt = EXPIRED;
            end
        end
    end

    always_comb begin
        nxt_zero       = (min_nxt == '0) && (tens_nxt == '0) && (ones_nxt == '0);
        nxt_above_warn = (min_nxt > W_MIN) ||
                         ((min_nxt == W_MIN) && ((tens_nxt > W_TENS) ||
                          ((tens_nxt == W_TENS) && (ones_nxt > W_ONES))));
        warn_nxt  = ((state_nxt == RUN) || (state_nxt == PAUSE)) && !nxt_above_warn && !nxt_zero;
        blink_nxt = 1'b0;
        if (warn_nxt && warn)
            blink_nxt = blink_adv ? ~blink : blink;
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            time_min      <= LD_MIN;
            time_sec_tens <= LD_TENS;
            time_sec_ones <= LD_ONES;
            running       <= 1'b0;
            warn          <= 1'b0;
            blink         <= 1'b0;
            expired       <= 1'b0;
            expire_pulse  <= 1'b0;
        end else begin
            state         <= state_nxt;
            time_min      <= min_nxt;
            time_sec_tens <= tens_nxt;
            time_sec_ones <= ones_nxt;
            running       <= (state_nxt == RUN);
            warn          <= warn_nxt;
            blink         <= blink_nxt;
            expired       <= (state_nxt == EXPIRED);
            expire_pulse  <= (state_nxt == EXPIRED) && (state != EXPIRED);
        end
    end

endmodule

// File: tb/tb_round_timer.sv
// tb/tb_round_timer.sv - directed scoreboard bench for round_timer
module tb_round_timer;

    logic clk;
    logic rst_n;
    logic c500;
    logic start_a, pause_a, clear_a;
    logic start_b, pause_b, clear_b;
    logic start_c, pause_c, clear_c;

    logic [3:0] min_a, min_b, min_c;
    logic [2:0] tens_a, tens_b, tens_c;
    logic [3:0] ones_a, ones_b, ones_c;
    logic run_a, warn_a, blink_a, exp_a, xp_a;
    logic run_b, warn_b, blink_b, exp_b, xp_b;
    logic run_c, warn_c, blink_c, exp_c, xp_c;

    logic [11:0] disp_a, disp_b, disp_c;
    assign disp_a = {min_a, 1'b0, tens_a, ones_a};
    assign disp_b = {min_b, 1'b0, tens_b, ones_b};
    assign disp_c = {min_c, 1'b0, tens_c, ones_c};

    int checks = 0;
    int failures = 0;
    logic [11:0] qa[$];
    logic [11:0] qb[$];
    logic [11:0] qc[$];
    logic [11:0] ea;

    round_timer #(.ROUND_SECS(180), .WARN_SECS(10), .SYNC_STAGES(2)) dut_a (
        .clk_100mhz(clk), .rst_n(rst_n), .clk_500ms(c500),
        .start(start_a), .pause(pause_a), .clear(clear_a),
        .time_min(min_a), .time_sec_tens(tens_a), .time_sec_ones(ones_a),
        .running(run_a), .warn(warn_a), .blink(blink_a),
        .expired(exp_a), .expire_pulse(xp_a));

    round_timer #(.ROUND_SECS(61), .WARN_SECS(10), .SYNC_STAGES(2)) dut_b (
        .clk_100mhz(clk), .rst_n(rst_n), .clk_500ms(c500),
        .start(start_b), .pause(pause_b), .clear(clear_b),
        .time_min(min_b), .time_sec_tens(tens_b), .time_sec_ones(ones_b),
        .running(run_b), .warn(warn_b), .blink(blink_b),
        .expired(exp_b), .expire_pulse(xp_b));

    round_timer #(.ROUND_SECS(12), .WARN_SECS(10), .SYNC_STAGES(2)) dut_c (
        .clk_100mhz(clk), .rst_n(rst_n), .clk_500ms(c500),
        .start(start_c), .pause(pause_c), .clear(clear_c),
        .time_min(min_c), .time_sec_tens(tens_c), .time_sec_ones(ones_c),
        .running(run_c), .warn(warn_c), .blink(blink_c),
        .expired(exp_c), .expire_pulse(xp_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_all();
        while (qa.size() > 0) chk("tick_a", disp_a, qa.pop_front());
        while (qb.size() > 0) chk("tick_b", disp_b, qb.pop_front());
        while (qc.size() > 0) chk("tick_c", disp_c, qc.pop_front());
    endtask

    task automatic rise();
        c500 = 1'b1;
        step(3);
        pop_all();
    endtask

    task automatic fall();
        c500 = 1'b0;
        step(3);
    endtask

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] m, o;
        logic [2:0] t;
        m = v[11:8]; t = v[6:4]; o = v[3:0];
        if (v == 12'h000) return v;
        if (o != 0) o = o - 1;
        else begin
            o = 9;
            if (t != 0) t = t - 1;
            else begin t = 5; m = m - 1; end
        end
        return {m, 1'b0, t, o};
    endfunction

    initial begin
        rst_n = 1'b0; c500 = 1'b0;
        {start_a, pause_a, clear_a} = '0;
        {start_b, pause_b, clear_b} = '0;
        {start_c, pause_c, clear_c} = '0;
        step(3);
        chk("reset_disp_a", disp_a, 12'h300);
        chk("reset_disp_b", disp_b, 12'h101);
        chk("reset_disp_c", disp_c, 12'h012);
        chk("reset_flags_a", {7'd0, run_a, warn_a, blink_a, exp_a, xp_a}, 12'h0);
        rst_n = 1'b1;
        step(4);

        // basic countdown with latency check
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("start_run_a", {11'd0, run_a}, 12'h1);
        chk("start_disp_a", disp_a, 12'h300);
        c500 = 1'b1; step(2);
        chk("latency_hold", disp_a, 12'h300);
        step();
        chk("latency_upd", disp_a, 12'h259);
        fall();
        qa.push_back(12'h258); rise(); fall();
        qa.push_back(12'h257); rise(); fall();
        chk("run_warn_a", {10'd0, run_a, warn_a}, 12'h2);

        // pause at 2:50
        ea = 12'h257;
        repeat (7) begin ea = bcd_dec(ea); qa.push_back(ea); rise(); fall(); end
        chk("at_250", disp_a, 12'h250);
        pause_a = 1'b1; step(); pause_a = 1'b0;
        chk("paused_run", {11'd0, run_a}, 12'h0);
        repeat (5) begin qa.push_back(12'h250); rise(); fall(); end
        pause_a = 1'b1; step(); pause_a = 1'b0;
        chk("resumed_run", {11'd0, run_a}, 12'h1);
        qa.push_back(12'h249); rise(); fall();

        // clear + start + sec_tick together
        c500 = 1'b1; step(2);
        clear_a = 1'b1; start_a = 1'b1; step();
        clear_a = 1'b0; start_a = 1'b0;
        chk("clr_start_disp", disp_a, 12'h300);
        chk("clr_start_run", {11'd0, run_a}, 12'h0);
        fall();
        start_a = 1'b1; step(); start_a = 1'b0;
        qa.push_back(12'h259); rise(); fall();
        // start + sec_tick in RUN
        c500 = 1'b1; step(2);
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("restart_disp", disp_a, 12'h300);
        chk("restart_run", {11'd0, run_a}, 12'h1);
        fall();
        clear_a = 1'b1; step(); clear_a = 1'b0;

        // borrow chain, 61 s
        start_b = 1'b1; step(); start_b = 1'b0;
        qb.push_back(12'h100); rise(); fall();
        qb.push_back(12'h059); rise(); fall();

        // expiry, 12 s with warn at 10
        start_c = 1'b1; step(); start_c = 1'b0;
        chk("c_start_warn", {11'd0, warn_c}, 12'h0);
        qc.push_back(12'h011); rise(); fall();
        chk("c_011_warn", {11'd0, warn_c}, 12'h0);
        qc.push_back(12'h010); rise();
        chk("c_010_warnblink", {10'd0, warn_c, blink_c}, 12'h2);
        fall();
        chk("c_blink_fall", {11'd0, blink_c}, 12'h1);
        ea = 12'h010;
        repeat (9) begin
            ea = bcd_dec(ea); qc.push_back(ea); rise();
            chk("c_blink_rise", {10'd0, warn_c, blink_c}, 12'h2);
            fall();
            chk("c_blink_fall", {10'd0, warn_c, blink_c}, 12'h3);
        end
        chk("c_at_001", disp_c, 12'h001);
        c500 = 1'b1; step(3);
        chk("c_expire_disp", disp_c, 12'h000);
        chk("c_expire_flags", {7'd0, run_c, warn_c, blink_c, exp_c, xp_c}, 12'h3);
        step();
        chk("c_pulse_one_cycle", {10'd0, exp_c, xp_c}, 12'h2);
        fall();
        repeat (2) begin
            qc.push_back(12'h000); rise(); fall();
            chk("c_hold_expired", {10'd0, exp_c, xp_c}, 12'h2);
        end

        // async reset mid-run at 1:23
        start_a = 1'b1; step(); start_a = 1'b0;
        ea = 12'h300;
        repeat (97) begin ea = bcd_dec(ea); qa.push_back(ea); rise(); fall(); end
        chk("a_at_123", disp_a, 12'h123);
        #2 rst_n = 1'b0;
        #1;
        chk("async_disp_a", disp_a, 12'h300);
        chk("async_flags_a", {7'd0, run_a, warn_a, blink_a, exp_a, xp_a}, 12'h0);
        chk("async_flags_c", {10'd0, exp_c, xp_c}, 12'h0);
        c500 = 1'b1;
        step(2);
        rst_n = 1'b1; start_a = 1'b1; step(); start_a = 1'b0;
        step(8);
        chk("no_tick_high_at_rel", disp_a, 12'h300);
        chk("run_after_rel", {11'd0, run_a}, 12'h1);
        fall();
        qa.push_back(12'h259); rise(); fall();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
